// File: rtl/controle_multiciclo_pkg.sv
// Shared encodings for the multicycle controller: state codes, the opcodes
// it decodes, and the ALU operation / PC source selectors it drives.
package controle_multiciclo_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_REXEC    = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/controle_multiciclo.sv
// Multicycle MIPS-subset control unit: state register plus combinational
// next-state and control-signal decode.
//
// state      | meaning
// -----------+-------------------------------------------------------
// FETCH      | read instruction, PC+4; waits on mem_ready
// DECODE     | register read, branch target calc, dispatch on Op_code
// MEMADDR    | effective address for lw/sw
// MEMREAD    | data memory read; waits on mem_ready
// MEMWB      | write loaded word to rt
// MEMWRITE   | data memory write; waits on mem_ready
// REXEC      | R-type ALU operation (funct)
// RWB        | write ALU result to rd
// BRANCH     | bne compare, conditional PC write
// JUMP       | unconditional PC write with jump target
// ADDIEXEC   | rs + sign-extended immediate
// ADDIWB     | write ALU result to rt
module controle_multiciclo
  import controle_multiciclo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op_code,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       ReadMem,
  output logic       WriteMem,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       WriteReg,
  output logic       OrigALUA,
  output logic [1:0] PCSource,
  output logic [1:0] OrigALUB,
  output logic [1:0] Op_ALU,
  output logic [3:0] state,
  output logic       illegal_op,
  output logic       instr_done
);

  state_t state_q;
  state_t state_d;

  assign state = state_q;

  // State register; reset is synchronous and always returns to FETCH.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and control decode; reset masks every output so an aborted
  // instruction cannot complete a register or memory write.
  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    ReadMem     = 1'b0;
    WriteMem    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    WriteReg    = 1'b0;
    OrigALUA    = 1'b0;
    PCSource    = PCSRC_ALU;
    OrigALUB    = 2'b00;
    Op_ALU      = ALU_ADD;
    illegal_op  = 1'b0;
    instr_done  = 1'b0;

    case (state_q)
      S_FETCH: begin
        ReadMem  = 1'b1;
        OrigALUB = 2'b01;
        IRWrite  = mem_ready;
        PCWrite  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        OrigALUB = 2'b11;
        case (Op_code)
          OP_RTYPE:     state_d = S_REXEC;
          OP_LW, OP_SW: state_d = S_MEMADDR;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_BNE:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEMADDR: begin
        OrigALUA = 1'b1;
        OrigALUB = 2'b10;
        // Opcode is re-examined here; if it no longer names lw/sw the
        // instruction is dropped as illegal rather than guessed at.
        if (Op_code == OP_LW)      state_d = S_MEMREAD;
        else if (Op_code == OP_SW) state_d = S_MEMWRITE;
        else begin
          state_d    = S_FETCH;
          illegal_op = 1'b1;
        end
      end
      S_MEMREAD: begin
        ReadMem = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg   = 1'b1;
        WriteReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        WriteMem = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_REXEC: begin
        OrigALUA = 1'b1;
        Op_ALU   = ALU_FUNCT;
        state_d  = S_RWB;
      end
      S_RWB: begin
        RegDst     = 1'b1;
        WriteReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        OrigALUA    = 1'b1;
        Op_ALU      = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEXEC: begin
        OrigALUA = 1'b1;
        OrigALUB = 2'b10;
        state_d  = S_ADDIWB;
      end
      S_ADDIWB: begin
        WriteReg   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (!rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      ReadMem     = 1'b0;
      WriteMem    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      WriteReg    = 1'b0;
      OrigALUA    = 1'b0;
      PCSource    = PCSRC_ALU;
      OrigALUB    = 2'b00;
      Op_ALU      = ALU_ADD;
      illegal_op  = 1'b0;
      instr_done  = 1'b0;
    end
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed testbench for controle_multiciclo. Inputs change on the falling
// edge; outputs are sampled 1ns later, so each drive() shows the outputs of
// the current state, and the following rising edge advances the FSM.
module tb_controle_multiciclo;
  import controle_multiciclo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Op_code = 6'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, ReadMem, WriteMem, IRWrite;
  logic       MemtoReg, RegDst, WriteReg, OrigALUA;
  logic [1:0] PCSource, OrigALUB, Op_ALU;
  logic [3:0] state;
  logic       illegal_op, instr_done;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  controle_multiciclo dut (
    .clk(clk), .rst_n(rst_n), .Op_code(Op_code), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .ReadMem(ReadMem), .WriteMem(WriteMem), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .WriteReg(WriteReg),
    .OrigALUA(OrigALUA), .PCSource(PCSource), .OrigALUB(OrigALUB),
    .Op_ALU(Op_ALU), .state(state), .illegal_op(illegal_op),
    .instr_done(instr_done)
  );

  task automatic drive(input logic [5:0] op, input logic mr, input logic rn);
    @(negedge clk);
    Op_code   = op;
    mem_ready = mr;
    rst_n     = rn;
    #1;
  endtask

  task automatic test_reset();
    drive(OP_LW, 1'b1, 1'b0);
    n_checks++;
    if ({ReadMem, IRWrite, PCWrite, WriteMem, WriteReg, PCWriteCond} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b expected 000000",
               {ReadMem, IRWrite, PCWrite, WriteMem, WriteReg, PCWriteCond});
    end
    drive(OP_LW, 1'b1, 1'b0);
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL reset_state: got %0d expected 0", state);
    end
    n_checks++;
    if ({illegal_op, instr_done} !== 2'b00) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00", {illegal_op, instr_done});
    end
    drive(OP_J, 1'b0, 1'b1);
    n_checks++;
    if ({ReadMem, IorD, OrigALUA, OrigALUB, Op_ALU, PCSource} !== 9'b1_0_0_01_00_00) begin
      n_fail++;
      $display("FAIL first_fetch: got %b expected 100010000",
               {ReadMem, IorD, OrigALUA, OrigALUB, Op_ALU, PCSource});
    end
  endtask

  task automatic test_fetch_stall();
    logic       mr  [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0] exp [5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd9};
    for (int i = 0; i < 5; i++) begin
      drive(OP_J, mr[i], 1'b1);
      n_checks++;
      if (state !== exp[i]) begin
        n_fail++; $display("FAIL stall_state[%0d]: got %0d expected %0d", i, state, exp[i]);
      end
      n_checks++;
      if (IRWrite !== (i == 2)) begin
        n_fail++; $display("FAIL stall_irwrite[%0d]: got %b expected %b", i, IRWrite, (i == 2));
      end
      n_checks++;
      if (PCWrite !== (i == 2 || i == 4)) begin
        n_fail++;
        $display("FAIL stall_pcwrite[%0d]: got %b expected %b", i, PCWrite, (i == 2 || i == 4));
      end
      if (i == 3) begin
        n_checks++;
        if (OrigALUB !== 2'b11) begin
          n_fail++; $display("FAIL decode_alub: got %b expected 11", OrigALUB);
        end
      end
      if (i == 4) begin
        n_checks++;
        if ({PCSource, instr_done} !== 3'b10_1) begin
          n_fail++; $display("FAIL jump_outputs: got %b expected 101", {PCSource, instr_done});
        end
      end
    end
    drive(OP_J, 1'b0, 1'b1);
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL jump_return: got %0d expected 0", state);
    end
  endtask

  task automatic test_lw();
    logic [3:0] exp [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
    logic [5:0] ops [5] = '{OP_J, OP_LW, OP_LW, OP_J, OP_J};
    int done_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(ops[i], 1'b1, 1'b1);
      n_checks++;
      if (state !== exp[i]) begin
        n_fail++; $display("FAIL lw_state[%0d]: got %0d expected %0d", i, state, exp[i]);
      end
      n_checks++;
      if ({WriteReg, MemtoReg} !== {(i == 4), (i == 4)}) begin
        n_fail++;
        $display("FAIL lw_writeback[%0d]: got %b expected %b", i, {WriteReg, MemtoReg},
                 {(i == 4), (i == 4)});
      end
      if (i == 2) begin
        n_checks++;
        if ({OrigALUA, OrigALUB, Op_ALU} !== 5'b1_10_00) begin
          n_fail++; $display("FAIL lw_memaddr: got %b expected 11000", {OrigALUA, OrigALUB, Op_ALU});
        end
      end
      if (i == 3) begin
        n_checks++;
        if ({ReadMem, IorD, WriteMem} !== 3'b110) begin
          n_fail++; $display("FAIL lw_memread: got %b expected 110", {ReadMem, IorD, WriteMem});
        end
      end
      if (instr_done === 1'b1) done_cnt++;
    end
    drive(OP_J, 1'b0, 1'b1);
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL lw_return: got %0d expected 0", state);
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++; $display("FAIL lw_done_count: got %0d expected 1", done_cnt);
    end
  endtask

  task automatic test_sw_wait();
    logic [3:0] exp [7] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5};
    logic [5:0] ops [7] = '{OP_J, OP_SW, OP_SW, OP_J, OP_LW, OP_RTYPE, OP_J};
    logic       mr  [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      drive(ops[i], mr[i], 1'b1);
      n_checks++;
      if (state !== exp[i]) begin
        n_fail++; $display("FAIL sw_state[%0d]: got %0d expected %0d", i, state, exp[i]);
      end
      n_checks++;
      if ({WriteMem, IorD} !== {(i >= 3), (i >= 3)}) begin
        n_fail++;
        $display("FAIL sw_writemem[%0d]: got %b expected %b", i, {WriteMem, IorD},
                 {(i >= 3), (i >= 3)});
      end
      n_checks++;
      if (instr_done !== (i == 6)) begin
        n_fail++; $display("FAIL sw_done[%0d]: got %b expected %b", i, instr_done, (i == 6));
      end
    end
    drive(OP_J, 1'b0, 1'b1);
    n_checks++;
    if ({state, WriteMem} !== 5'b0000_0) begin
      n_fail++; $display("FAIL sw_return: got %b expected 00000", {state, WriteMem});
    end
  endtask

  task automatic test_bne();
    logic [3:0] exp [3] = '{4'd0, 4'd1, 4'd8};
    logic [5:0] ops [3] = '{OP_J, OP_BNE, OP_J};
    for (int i = 0; i < 3; i++) begin
      drive(ops[i], 1'b1, 1'b1);
      n_checks++;
      if (state !== exp[i]) begin
        n_fail++; $display("FAIL bne_state[%0d]: got %0d expected %0d", i, state, exp[i]);
      end
      n_checks++;
      if (PCWriteCond !== (i == 2)) begin
        n_fail++; $display("FAIL bne_pcwc[%0d]: got %b expected %b", i, PCWriteCond, (i == 2));
      end
    end
    n_checks++;
    if ({PCSource, Op_ALU, OrigALUA, OrigALUB, instr_done, PCWrite} !== 8'b01_01_1_00_1_0) begin
      n_fail++;
      $display("FAIL bne_outputs: got %b expected 01011001",
               {PCSource, Op_ALU, OrigALUA, OrigALUB, instr_done, PCWrite});
    end
    drive(OP_J, 1'b0, 1'b1);
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL bne_return: got %0d expected 0", state);
    end
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 2; i++) begin
      drive(6'b111111, 1'b1, 1'b1);
      n_checks++;
      if (state !== 4'(i)) begin
        n_fail++; $display("FAIL illegal_state[%0d]: got %0d expected %0d", i, state, i);
      end
      n_checks++;
      if (illegal_op !== (i == 1)) begin
        n_fail++; $display("FAIL illegal_flag[%0d]: got %b expected %b", i, illegal_op, (i == 1));
      end
      n_checks++;
      if ({WriteReg, WriteMem, instr_done} !== 3'b000) begin
        n_fail++;
        $display("FAIL illegal_writes[%0d]: got %b expected 000", i, {WriteReg, WriteMem, instr_done});
      end
    end
    drive(6'b111111, 1'b0, 1'b1);
    n_checks++;
    if ({state, illegal_op} !== 5'b0000_0) begin
      n_fail++; $display("FAIL illegal_return: got %b expected 00000", {state, illegal_op});
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] dec_op [2] = '{OP_RTYPE, OP_ADDI};
    logic [3:0] s_exec [2] = '{4'd6, 4'd10};
    logic [3:0] s_wb   [2] = '{4'd7, 4'd11};
    logic [1:0] alu    [2] = '{ALU_FUNCT, ALU_ADD};
    logic [1:0] alub   [2] = '{2'b00, 2'b10};
    logic       rdst   [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 2; k++) begin
      drive(OP_J, 1'b1, 1'b1);
      n_checks++;
      if (state !== 4'd0) begin
        n_fail++; $display("FAIL b2b_fetch[%0d]: got %0d expected 0", k, state);
      end
      drive(dec_op[k], 1'b1, 1'b1);
      n_checks++;
      if (state !== 4'd1) begin
        n_fail++; $display("FAIL b2b_decode[%0d]: got %0d expected 1", k, state);
      end
      drive(OP_LW, 1'b1, 1'b1);
      n_checks++;
      if ({state, OrigALUA, OrigALUB, Op_ALU, WriteReg} !== {s_exec[k], 1'b1, alub[k], alu[k], 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_exec[%0d]: got %b expected %b", k, {state, OrigALUA, OrigALUB, Op_ALU, WriteReg},
                 {s_exec[k], 1'b1, alub[k], alu[k], 1'b0});
      end
      drive(OP_SW, 1'b1, 1'b1);
      n_checks++;
      if ({state, RegDst, MemtoReg, WriteReg, instr_done} !== {s_wb[k], rdst[k], 1'b0, 1'b1, 1'b1}) begin
        n_fail++;
        $display("FAIL b2b_wb[%0d]: got %b expected %b", k, {state, RegDst, MemtoReg, WriteReg, instr_done},
                 {s_wb[k], rdst[k], 1'b0, 1'b1, 1'b1});
      end
    end
    drive(OP_J, 1'b0, 1'b1);
    n_checks++;
    if (state !== 4'd0) begin
      n_fail++; $display("FAIL b2b_return: got %0d expected 0", state);
    end
  endtask

  task automatic test_reset_mid_write();
    drive(OP_J, 1'b1, 1'b1);
    drive(OP_SW, 1'b1, 1'b1);
    drive(OP_SW, 1'b1, 1'b1);
    drive(OP_SW, 1'b0, 1'b1);
    n_checks++;
    if ({state, WriteMem} !== 5'b0101_1) begin
      n_fail++; $display("FAIL rmid_pre: got %b expected 01011", {state, WriteMem});
    end
    drive(OP_SW, 1'b0, 1'b0);
    n_checks++;
    if ({state, WriteMem, IorD, instr_done} !== 7'b0101_000) begin
      n_fail++;
      $display("FAIL rmid_cycle1: got %b expected 0101000", {state, WriteMem, IorD, instr_done});
    end
    drive(OP_SW, 1'b1, 1'b0);
    n_checks++;
    if ({state, WriteMem} !== 5'b0000_0) begin
      n_fail++; $display("FAIL rmid_cycle2: got %b expected 00000", {state, WriteMem});
    end
    drive(OP_SW, 1'b1, 1'b1);
    n_checks++;
    if ({state, ReadMem, IRWrite, PCWrite, WriteMem} !== 8'b0000_1110) begin
      n_fail++;
      $display("FAIL rmid_release: got %b expected 00001110", {state, ReadMem, IRWrite, PCWrite, WriteMem});
    end
    drive(OP_J, 1'b1, 1'b1);
    n_checks++;
    if ({state, WriteMem, WriteReg} !== 6'b0001_00) begin
      n_fail++; $display("FAIL rmid_decode: got %b expected 000100", {state, WriteMem, WriteReg});
    end
    drive(OP_J, 1'b1, 1'b1);
    n_checks++;
    if ({state, WriteMem, WriteReg} !== 6'b1001_00) begin
      n_fail++; $display("FAIL rmid_jump: got %b expected 100100", {state, WriteMem, WriteReg});
    end
  endtask

  initial begin
    test_reset();
    test_fetch_stall();
    test_lw();
    test_sw_wait();
    test_bne();
    test_illegal();
    test_back_to_back();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
